// File: rtl/mips_pkg.sv
// Shared datapath constants for the execute-stage dispatch blocks.
package mips_pkg;

   localparam int   DATA_W = 32;
   localparam logic SEL_A  = 1'b0;
   localparam logic SEL_B  = 1'b1;

endpackage

// File: rtl/demux2way32_pipe_fifo2.sv
// Two-entry register FIFO (fifo2): head/tail registers with an occupancy count.
module fifo2
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == 2'(DEPTH));
   assign empty   = (count_q == 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10: begin
            if (count_q == 2'd0) head_d = din;
            else                 tail_d = din;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // Push and pop together is only possible at count 1 (push refused when full).
         2'b11:   head_d = din;
         default: ;
      endcase
   end

   // NOTE: the data registers are reset too, because the outputs must read zero while in reset.
   // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign count = count_q;

endmodule

// File: rtl/demux2way32_pipe.sv
// Elastic 1-to-2 router: steers each word by in_sel into one of two 2-entry FIFOs.
module demux2way32_pipe
   import mips_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic [1:0]       a_count,
   output logic [1:0]       b_count
);

   logic a_full, a_empty, b_full, b_empty;
   logic accept, push_a, push_b;

   // Readiness looks only at the selected branch's registered fullness, never at consumer readies.
   assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
   assign accept   = in_valid && in_ready;
   assign push_a   = accept && (in_sel == SEL_A);
   assign push_b   = accept && (in_sel == SEL_B);

   fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_a),
      .pop   (a_ready),
      .din   (in_data),
      .dout  (a_data),
      .full  (a_full),
      .empty (a_empty),
      .count (a_count)
   );

   fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_b),
      .pop   (b_ready),
      .din   (in_data),
      .dout  (b_data),
      .full  (b_full),
      .empty (b_empty),
      .count (b_count)
   );

   assign a_valid = !a_empty;
   assign b_valid = !b_empty;

endmodule

// File: tb/tb_demux2way32_pipe.sv
// Directed bench for demux2way32_pipe with per-branch expected-word queues.
module tb_demux2way32_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_sel = 1'b0;
   logic        a_valid, b_valid;
   logic        a_ready = 1'b0, b_ready = 1'b0;
   logic [31:0] a_data, b_data;
   logic [1:0]  a_count, b_count;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_a[$];
   logic [31:0] exp_b[$];

   always #5 clk = ~clk;

   demux2way32_pipe dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Record the word the DUT takes at the coming rising edge (called at the falling edge).
   task automatic commit();
      if (in_valid && in_ready) begin
         if (in_sel) exp_b.push_back(in_data);
         else        exp_a.push_back(in_data);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   // Scoreboard: every handshake on an output branch must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            check("a_pop_expected", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) check("a_order", a_data, exp_a.pop_front());
         end
         if (b_valid && b_ready) begin
            check("b_pop_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) check("b_order", b_data, exp_b.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #3;
      check("rst_a_valid", 32'(a_valid), 32'd0);
      check("rst_b_valid", 32'(b_valid), 32'd0);
      check("rst_a_count", 32'(a_count), 32'd0);
      check("rst_b_count", 32'(b_count), 32'd0);
      check("rst_a_data", a_data, 32'd0);
      check("rst_b_data", b_data, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;

      // Single word to A, visible for exactly one cycle
      a_ready = 1'b1;
      b_ready = 1'b1;
      drive(1'b1, 1'b0, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      commit();
      next_cycle();
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t1_a_valid", 32'(a_valid), 32'd1);
      check("t1_a_data", a_data, 32'hDEADBEEF);
      check("t1_b_valid", 32'(b_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("t1_a_valid_drop", 32'(a_valid), 32'd0);
      next_cycle();

      // Branch B backpressure does not block A
      b_ready = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         drive(1'b1, 1'b1, 32'(k));
         @(negedge clk);
         check("t2_b_accept", 32'(in_ready), 32'd1);
         commit();
         next_cycle();
      end
      drive(1'b1, 1'b1, 32'd3);
      @(negedge clk);
      check("t2_b_full_count", 32'(b_count), 32'd2);
      check("t2_b_full_refuse", 32'(in_ready), 32'd0);
      commit();
      next_cycle();
      drive(1'b1, 1'b0, 32'h55);
      @(negedge clk);
      check("t2_a_while_b_full", 32'(in_ready), 32'd1);
      commit();
      next_cycle();
      drive(1'b1, 1'b1, 32'd3);
      @(negedge clk);
      check("t2_a_55_valid", 32'(a_valid), 32'd1);
      check("t2_a_55_data", a_data, 32'h55);
      b_ready = 1'b1;
      #1;
      check("t2_refuse_on_pop", 32'(in_ready), 32'd0);
      check("t2_b_head1", b_data, 32'd1);
      commit();
      next_cycle();
      @(negedge clk);
      check("t2_b_count1", 32'(b_count), 32'd1);
      check("t2_b_head2", b_data, 32'd2);
      check("t2_retry_accept", 32'(in_ready), 32'd1);
      commit();
      next_cycle();
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t2_b_head3", b_data, 32'd3);
      next_cycle();
      next_cycle();
      check("t2_drained_a", 32'(a_count), 32'd0);
      check("t2_drained_b", 32'(b_count), 32'd0);

      // Alternating stream at full rate, one-cycle latency
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i[0], 32'h1000 + 32'(i));
         @(negedge clk);
         check("t3_in_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            if (i[0]) check("t3_a_latency", a_data, 32'h1000 + 32'(i - 1));
            else      check("t3_b_latency", b_data, 32'h1000 + 32'(i - 1));
         end
         commit();
         next_cycle();
      end
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t3_last_valid", 32'(b_valid), 32'd1);
      check("t3_last_data", b_data, 32'h100F);
      next_cycle();
      next_cycle();

      // Push and pop together at count 1 on A
      a_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h200);
      @(negedge clk);
      commit();
      next_cycle();
      a_ready = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         drive(1'b1, 1'b0, 32'h200 + 32'(k));
         @(negedge clk);
         check("t4_count_steady", 32'(a_count), 32'd1);
         check("t4_in_ready", 32'(in_ready), 32'd1);
         commit();
         next_cycle();
      end
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t4_tail_head", a_data, 32'h202);
      next_cycle();
      @(negedge clk);
      check("t4_empty", 32'(a_count), 32'd0);
      next_cycle();

      // Full branch with same-cycle pop refuses; retry completes
      a_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h300 + 32'(k));
         @(negedge clk);
         commit();
         next_cycle();
      end
      a_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h302);
      @(negedge clk);
      check("t5_full_count", 32'(a_count), 32'd2);
      check("t5_refuse", 32'(in_ready), 32'd0);
      commit();
      next_cycle();
      a_ready = 1'b0;
      @(negedge clk);
      check("t5_retry_ready", 32'(in_ready), 32'd1);
      check("t5_count_one", 32'(a_count), 32'd1);
      commit();
      next_cycle();
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t5_count_back2", 32'(a_count), 32'd2);
      a_ready = 1'b1;
      next_cycle();
      next_cycle();
      next_cycle();
      check("t5_drained", 32'(a_count), 32'd0);

      // Asynchronous reset with both branches full
      a_ready = 1'b0;
      b_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k[0], 32'h400 + 32'(k));
         @(negedge clk);
         commit();
         next_cycle();
      end
      drive(1'b0, 1'b0, 32'h0);
      check("t6_a_full", 32'(a_count), 32'd2);
      check("t6_b_full", 32'(b_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_a_valid_rst", 32'(a_valid), 32'd0);
      check("t6_b_valid_rst", 32'(b_valid), 32'd0);
      check("t6_a_count_rst", 32'(a_count), 32'd0);
      check("t6_b_count_rst", 32'(b_count), 32'd0);
      check("t6_in_ready_rst", 32'(in_ready), 32'd1);
      exp_a.delete();
      exp_b.delete();
      next_cycle();
      rst_n = 1'b1;
      b_ready = 1'b1;
      drive(1'b1, 1'b1, 32'hCAFE0001);
      @(negedge clk);
      check("t6_post_ready", 32'(in_ready), 32'd1);
      commit();
      next_cycle();
      drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("t6_post_b_valid", 32'(b_valid), 32'd1);
      check("t6_post_b_data", b_data, 32'hCAFE0001);
      check("t6_post_a_valid", 32'(a_valid), 32'd0);
      next_cycle();
      next_cycle();

      check("end_a_queue_empty", 32'(exp_a.size()), 32'd0);
      check("end_b_queue_empty", 32'(exp_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
